br_resolve: RTL and testbench
=============================

// Module: br_resolve
// PURPOSE
//  EX-stage branch resolution, directly downstream of the branch ALU.
//  - Compares the ALU outcome (taken flag, computed target) with the frontend prediction.
//  - Raises a registered pipeline flush plus redirect PC on a mispredict.
//  - Queues predictor/TAGE update packets in a small FIFO toward the frontend.
//  - Keeps branch and mispredict statistics counters.
// PARAMETERS
//  QDEPTH   4   update FIFO entries (power of 2, >=2)
//  CNTW     32  statistics counter width (saturating)
// PORTS
//  clk            in   1   clock
//  rstn           in   1   async active-low reset
//  ex_valid       in   1   EX slot holds a live instruction this cycle
//  ex_stall       in   1   EX held; input is not consumed
//  ctr            in   32  decoded control word; [3:0] type, 1 = cond/uncond branch, 8 = jump
//  pc             in   32  instruction PC
//  pre            in   76  prediction bundle; field map below
//  ifbr           in   1   ALU resolved taken
//  brresult       in   32  ALU resolved target
//  flush_pre      in   1   paired-slot prediction must be discarded
//  flush_o        out  1   registered flush to IF/ID/EX
//  redirect_pc    out  32  fetch restart PC, valid with flush_o
//  upd_valid      out  1   update packet available
//  upd_ready      in   1   predictor accepts packet
//  upd_pkt        out  110 {meta[36:0], pc[31:0], target[31:0], taken, mispred, is_jump, iftwo, 5'b0}
//  stall_req      out  1   FIFO cannot accept; hold EX
//  cnt_br         out  CNTW  resolved branches/jumps
//  cnt_mis        out  CNTW  mispredicts
// BEHAVIOUR
//  pre field map:
//   - [31:0] predicted target
//   - [33] predicted taken
//   - [34] predicted as branch
//   - [38] iftwo
//   - [75:39] TAGE meta
//   - other bits reserved
//  Accept: acc = ex_valid & ~ex_stall & ~stall_req & ~shadow.
//  is_br = type 1 or 8.
//  Mispredict when acc and any of:
//   - is_br & (ifbr != pre[33]) -> redirect = ifbr ? brresult : pc+4
//   - is_br & ifbr & pre[33] & (brresult != pre[31:0]) -> redirect = brresult
//   - ~is_br & pre[34] & pre[33] -> redirect = pc+4
//   - flush_pre -> redirect = pc+4 (highest priority)
//  Outputs:
//   - flush_o and redirect_pc are registered; asserted the cycle after acc, high exactly 1 cycle.
//   - shadow = flush_o. Input is ignored while flush_o is high (wrong-path slot); no update, no count.
//  Update FIFO:
//   - push on acc & is_br; mispred bit set from the compare.
//   - pop on upd_valid & upd_ready.
//   - Simultaneous push/pop when full is legal and keeps count.
//  stall_req = full & ~(upd_valid & upd_ready) (combinational).
//   - A push is never dropped: with stall_req high, acc is low.
//  Wrap: pointers are log2(QDEPTH)+1 bits; full/empty from MSB compare.
//  Counters:
//   - cnt_br++ on push.
//   - cnt_mis++ on acc & mispred (including non-branch cases).
//   - Both saturate at all-ones.
//  Reset (async, rstn low):
//   - flush_o=0, redirect_pc=0, FIFO empty, upd_valid=0, counters 0.
//   - Mid-operation reset discards queued packets.
//  upd_pkt is driven from the FIFO head; its value is don't-care while upd_valid=0.
// STRUCTURE
//  Shared package:
//   - PRE_* bit-index constants
//   - BR_TYPE_BRANCH=1, BR_TYPE_JUMP=8
//   - update packet width/layout
//  Sub-module br_upd_fifo: sync FIFO with valid/ready and full/empty.
//  Top holds the compare, redirect register and counters.
// TESTING
//  1. Correct taken: type1, pre[33]=1, pre[31:0]=0x1c00_0040, ifbr=1, brresult=0x1c00_0040
//     -> no flush, one packet mispred=0, cnt_br=1, cnt_mis=0.
//  2. Direction miss: pc=0x1c00_0100, pre[33]=0, ifbr=1, brresult=0x1c00_0200
//     -> next cycle flush_o=1, redirect_pc=0x1c00_0200, packet mispred=1.
//  3. Target miss: pre taken to 0x100, ALU taken to 0x180 -> redirect 0x180.
//     - Input driven during flush_o is ignored (no packet).
//  4. Backpressure: upd_ready=0, four branches fill FIFO
//     -> stall_req=1; 5th held until upd_ready=1; no loss, order preserved.
//  5. Full with simultaneous pop/push -> count stays QDEPTH, head advances.
//     - Counters saturate when preloaded to all-ones.
//  6. flush_pre=1 with non-branch at pc=0x1c00_0010 -> redirect 0x1c00_0014.
//     - rstn pulse mid-queue -> upd_valid=0 immediately.

Source files
------------

// File: rtl/br_resolve_pkg.sv
// Shared definitions for EX-stage branch resolution: prediction-bundle field map,
// branch type codes and the predictor update packet layout.
package br_resolve_pkg;

   localparam int unsigned XLEN         = 32;
   localparam int unsigned PRE_W        = 76;
   localparam int unsigned META_W       = 37;
   localparam int unsigned UPD_PAD_W    = 5;

   localparam int unsigned PRE_TGT_MSB  = 31;
   localparam int unsigned PRE_TAKEN    = 33;
   localparam int unsigned PRE_IS_BR    = 34;
   localparam int unsigned PRE_IFTWO    = 38;
   localparam int unsigned PRE_META_LSB = 39;
   localparam int unsigned PRE_META_MSB = 75;

   localparam logic [3:0] BR_TYPE_BRANCH = 4'd1;
   localparam logic [3:0] BR_TYPE_JUMP   = 4'd8;

   typedef struct packed {
      logic [META_W-1:0]    meta;
      logic [XLEN-1:0]      pc;
      logic [XLEN-1:0]      target;
      logic                 taken;
      logic                 mispred;
      logic                 is_jump;
      logic                 iftwo;
      logic [UPD_PAD_W-1:0] pad;
   } upd_pkt_t;

   localparam int unsigned UPD_PKT_W = $bits(upd_pkt_t);

   // Where the fetch restart address comes from after a mispredict.
   typedef enum logic [1:0] {
      REDIR_NONE   = 2'd0,
      REDIR_SEQ    = 2'd1,
      REDIR_TARGET = 2'd2
   } redir_src_e;

   function automatic logic is_branch_type(input logic [3:0] br_type);
      return (br_type == BR_TYPE_BRANCH) || (br_type == BR_TYPE_JUMP);
   endfunction

endpackage

// File: rtl/br_upd_fifo.sv
// Synchronous FIFO for predictor update packets; wrap-bit pointers give full/empty,
// and a push into a full FIFO is taken only when the head pops in the same cycle.
module br_upd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 110
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         push,
   input  logic [W-1:0] wdata,
   output logic         full,
   output logic         rvalid,
   input  logic         rready,
   output logic [W-1:0] rdata
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          empty;
   logic          do_push;
   logic          do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rvalid  = ~empty;
   assign do_pop  = rvalid & rready;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Payload storage needs no reset; it is only observed behind rvalid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/br_resolve.sv
// EX-stage branch resolution: compares ALU outcome with the frontend prediction,
// raises a one-cycle registered flush/redirect, queues predictor updates and counts.
module br_resolve
   import br_resolve_pkg::*;
#(
   parameter int unsigned QDEPTH = 4,
   parameter int unsigned CNTW   = 32
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 ex_valid,
   input  logic                 ex_stall,
   input  logic [XLEN-1:0]      ctr,
   input  logic [XLEN-1:0]      pc,
   input  logic [PRE_W-1:0]     pre,
   input  logic                 ifbr,
   input  logic [XLEN-1:0]      brresult,
   input  logic                 flush_pre,
   output logic                 flush_o,
   output logic [XLEN-1:0]      redirect_pc,
   output logic                 upd_valid,
   input  logic                 upd_ready,
   output logic [UPD_PKT_W-1:0] upd_pkt,
   output logic                 stall_req,
   output logic [CNTW-1:0]      cnt_br,
   output logic [CNTW-1:0]      cnt_mis
);

   logic [3:0]      br_type;
   logic            is_br;
   logic            is_jump;
   logic            pred_taken;
   logic            pred_br;
   logic [XLEN-1:0] pred_tgt;
   logic [XLEN-1:0] seq_pc;
   logic            full;
   logic            pop;
   logic            acc;
   logic            push;
   logic            mispred;
   redir_src_e      redir_src;
   logic [XLEN-1:0] redir_c;
   upd_pkt_t        pkt_in;
   logic            unused_bits;

   assign br_type    = ctr[3:0];
   assign is_br      = is_branch_type(br_type);
   assign is_jump    = (br_type == BR_TYPE_JUMP);
   assign pred_taken = pre[PRE_TAKEN];
   assign pred_br    = pre[PRE_IS_BR];
   assign pred_tgt   = pre[PRE_TGT_MSB:0];
   assign seq_pc     = pc + XLEN'(4);

   // Reserved prediction bits and upper control-word bits carry nothing here.
   assign unused_bits = ^{ctr[XLEN-1:4], pre[32], pre[37:35]};

   // The slot behind a flush is wrong-path, and a full FIFO without a pop holds EX.
   assign pop       = upd_valid & upd_ready;
   assign stall_req = full & ~pop;
   assign acc       = ex_valid & ~ex_stall & ~stall_req & ~flush_o;
   assign push      = acc & is_br;

   // Mispredict classification; a discarded paired-slot prediction wins.
   always_comb begin
      redir_src = REDIR_NONE;
      if (flush_pre) begin
         redir_src = REDIR_SEQ;
      end else if (is_br && (ifbr != pred_taken)) begin
         redir_src = ifbr ? REDIR_TARGET : REDIR_SEQ;
      end else if (is_br && ifbr && (brresult != pred_tgt)) begin
         redir_src = REDIR_TARGET;
      end else if (!is_br && pred_br && pred_taken) begin
         redir_src = REDIR_SEQ;
      end
   end

   assign mispred = (redir_src != REDIR_NONE);
   assign redir_c = (redir_src == REDIR_TARGET) ? brresult : seq_pc;

   always_comb begin
      pkt_in         = '0;
      pkt_in.meta    = pre[PRE_META_MSB:PRE_META_LSB];
      pkt_in.pc      = pc;
      pkt_in.target  = brresult;
      pkt_in.taken   = ifbr;
      pkt_in.mispred = mispred;
      pkt_in.is_jump = is_jump;
      pkt_in.iftwo   = pre[PRE_IFTWO];
   end

   br_upd_fifo #(
      .DEPTH (QDEPTH),
      .W     (UPD_PKT_W)
   ) u_fifo (
      .clk    (clk),
      .rstn   (rstn),
      .push   (push),
      .wdata  (pkt_in),
      .full   (full),
      .rvalid (upd_valid),
      .rready (upd_ready),
      .rdata  (upd_pkt)
   );

   // Flush pulses for exactly one cycle; redirect_pc holds its last value otherwise.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         flush_o     <= 1'b0;
         redirect_pc <= '0;
      end else begin
         flush_o <= acc & mispred;
         if (acc && mispred) redirect_pc <= redir_c;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_br  <= '0;
         cnt_mis <= '0;
      end else begin
         if (push && (cnt_br != '1))            cnt_br  <= cnt_br + CNTW'(1);
         if (acc && mispred && (cnt_mis != '1)) cnt_mis <= cnt_mis + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_br_resolve.sv
// Bench for br_resolve: directed vector table, backpressure/saturation/reset sequences,
// and random traffic checked every cycle against a queue-based behavioural model.
module tb_br_resolve;

   localparam int QD = 4;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         ex_valid = 1'b0;
   logic         s_valid = 1'b0;
   logic         ex_stall = 1'b0;
   logic [31:0]  ctr = '0;
   logic [31:0]  pc = '0;
   logic [75:0]  pre = '0;
   logic         ifbr = 1'b0;
   logic [31:0]  brresult = '0;
   logic         flush_pre = 1'b0;
   logic         upd_ready = 1'b0;

   logic         flush_o;
   logic [31:0]  redirect_pc;
   logic         upd_valid;
   logic [109:0] upd_pkt;
   logic         stall_req;
   logic [31:0]  cnt_br;
   logic [31:0]  cnt_mis;

   logic         s_flush;
   logic [31:0]  s_redir;
   logic         s_uvalid;
   logic [109:0] s_pkt;
   logic         s_stall;
   logic [1:0]   s_cbr;
   logic [1:0]   s_cmis;

   int total = 0;
   int bad   = 0;

   br_resolve #(.QDEPTH(QD), .CNTW(32)) dut (
      .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .ex_stall(ex_stall), .ctr(ctr),
      .pc(pc), .pre(pre), .ifbr(ifbr), .brresult(brresult), .flush_pre(flush_pre),
      .flush_o(flush_o), .redirect_pc(redirect_pc), .upd_valid(upd_valid),
      .upd_ready(upd_ready), .upd_pkt(upd_pkt), .stall_req(stall_req),
      .cnt_br(cnt_br), .cnt_mis(cnt_mis)
   );

   // Narrow counters so saturation is reachable in a few transactions.
   br_resolve #(.QDEPTH(2), .CNTW(2)) u_sat (
      .clk(clk), .rstn(rstn), .ex_valid(s_valid), .ex_stall(ex_stall), .ctr(ctr),
      .pc(pc), .pre(pre), .ifbr(ifbr), .brresult(brresult), .flush_pre(flush_pre),
      .flush_o(s_flush), .redirect_pc(s_redir), .upd_valid(s_uvalid),
      .upd_ready(1'b1), .upd_pkt(s_pkt), .stall_req(s_stall),
      .cnt_br(s_cbr), .cnt_mis(s_cmis)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   logic [109:0] mq[$];
   logic         m_flush = 1'b0;
   logic [31:0]  m_redir = '0;
   logic [31:0]  m_cbr = '0;
   logic [31:0]  m_cmis = '0;

   function automatic logic [109:0] mk_pkt(input logic [75:0] p, input logic [31:0] a,
                                           input logic [31:0] t, input logic tk,
                                           input logic mis, input logic j);
      return {p[75:39], a, t, tk, mis, j, p[38], 5'b0};
   endfunction

   task automatic model_step();
      bit pop_m, stall_m, acc_m, isbr, dir_miss, tgt_miss, nb_miss, mis;
      logic [31:0] nr;
      if (!rstn) begin
         mq.delete();
         m_flush = 1'b0;
         m_redir = '0;
         m_cbr   = '0;
         m_cmis  = '0;
         return;
      end
      check("m_flush", 128'(flush_o), 128'(m_flush));
      if (m_flush) check("m_redirect", 128'(redirect_pc), 128'(m_redir));
      check("m_upd_valid", 128'(upd_valid), 128'(mq.size() != 0));
      if (mq.size() != 0) check("m_upd_pkt", 128'(upd_pkt), 128'(mq[0]));
      pop_m   = (mq.size() != 0) && upd_ready;
      stall_m = (mq.size() == QD) && !pop_m;
      check("m_stall_req", 128'(stall_req), 128'(stall_m));
      check("m_cnt_br", 128'(cnt_br), 128'(m_cbr));
      check("m_cnt_mis", 128'(cnt_mis), 128'(m_cmis));

      acc_m    = ex_valid && !ex_stall && !stall_m && !m_flush;
      isbr     = (ctr[3:0] == 4'd1) || (ctr[3:0] == 4'd8);
      dir_miss = isbr && (ifbr != pre[33]);
      tgt_miss = isbr && ifbr && pre[33] && (brresult != pre[31:0]);
      nb_miss  = !isbr && pre[34] && pre[33];
      mis      = flush_pre || dir_miss || tgt_miss || nb_miss;
      if (flush_pre)     nr = pc + 32'd4;
      else if (dir_miss) nr = ifbr ? brresult : pc + 32'd4;
      else if (tgt_miss) nr = brresult;
      else               nr = pc + 32'd4;

      if (pop_m) void'(mq.pop_front());
      if (acc_m && isbr) begin
         mq.push_back(mk_pkt(pre, pc, brresult, ifbr, mis, ctr[3:0] == 4'd8));
         if (m_cbr != 32'hffff_ffff) m_cbr++;
      end
      if (acc_m && mis && (m_cmis != 32'hffff_ffff)) m_cmis++;
      m_flush = acc_m && mis;
      if (m_flush) m_redir = nr;
   endtask

   // One cycle: model observes this cycle at the falling edge, then inputs may change.
   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ex_valid  = 1'b0;
      s_valid   = 1'b0;
      ex_stall  = 1'b0;
      flush_pre = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rstn = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
   endtask

   function automatic logic [75:0] mkpre(input logic [31:0] tgt, input logic tk, input logic br);
      logic [75:0] p;
      p        = '0;
      p[31:0]  = tgt;
      p[33]    = tk;
      p[34]    = br;
      p[38]    = 1'b1;
      p[75:39] = 37'h12_3456_789a;
      return p;
   endfunction

   task automatic drive(input logic [31:0] c, input logic [31:0] a, input logic [75:0] p,
                        input logic tk, input logic [31:0] t, input logic fp);
      ctr = c; pc = a; pre = p; ifbr = tk; brresult = t; flush_pre = fp;
      ex_valid = 1'b1;
      ex_stall = 1'b0;
   endtask

   typedef struct {
      logic [31:0] ctr;
      logic [31:0] pc;
      logic [75:0] pre;
      logic        ifbr;
      logic [31:0] brres;
      logic        fp;
      logic        e_flush;
      logic [31:0] e_redir;
      logic        e_push;
      logic        e_mis;
   } vec_t;

   vec_t         tv[8];
   logic [109:0] hp;
   logic [31:0]  got[$];
   logic [31:0]  want[4];
   int           exp_br;
   int           exp_mis;

   initial begin
      tv[0] = '{32'd1, 32'h1c00_0000, mkpre(32'h1c00_0040, 1'b1, 1'b1), 1'b1, 32'h1c00_0040, 1'b0,
                1'b0, 32'h0, 1'b1, 1'b0};
      tv[1] = '{32'd1, 32'h1c00_0100, mkpre(32'h0, 1'b0, 1'b1), 1'b1, 32'h1c00_0200, 1'b0,
                1'b1, 32'h1c00_0200, 1'b1, 1'b1};
      tv[2] = '{32'd1, 32'h0000_0080, mkpre(32'h100, 1'b1, 1'b1), 1'b1, 32'h180, 1'b0,
                1'b1, 32'h180, 1'b1, 1'b1};
      tv[3] = '{32'd3, 32'h1c00_0010, 76'h0, 1'b0, 32'h0, 1'b1,
                1'b1, 32'h1c00_0014, 1'b0, 1'b1};
      tv[4] = '{32'd8, 32'h1c00_0300, mkpre(32'h1c00_2000, 1'b1, 1'b1), 1'b0, 32'h1c00_2000, 1'b0,
                1'b1, 32'h1c00_0304, 1'b1, 1'b1};
      tv[5] = '{32'd2, 32'h1c00_0400, mkpre(32'h1c00_5000, 1'b1, 1'b1), 1'b0, 32'h0, 1'b0,
                1'b1, 32'h1c00_0404, 1'b0, 1'b1};
      tv[6] = '{32'd1, 32'h1c00_0500, mkpre(32'h0, 1'b0, 1'b1), 1'b0, 32'h1c00_0600, 1'b0,
                1'b0, 32'h0, 1'b1, 1'b0};
      tv[7] = '{32'd1, 32'h1c00_0600, mkpre(32'h1c00_0700, 1'b1, 1'b1), 1'b1, 32'h1c00_0700, 1'b1,
                1'b1, 32'h1c00_0604, 1'b1, 1'b1};

      // Reset state
      do_reset();
      check("rst_flush", 128'(flush_o), 128'(0));
      check("rst_redirect", 128'(redirect_pc), 128'(0));
      check("rst_upd_valid", 128'(upd_valid), 128'(0));
      check("rst_stall", 128'(stall_req), 128'(0));
      check("rst_cnt_br", 128'(cnt_br), 128'(0));
      check("rst_cnt_mis", 128'(cnt_mis), 128'(0));

      // Directed vector table
      exp_br  = 0;
      exp_mis = 0;
      for (int i = 0; i < 8; i++) begin
         upd_ready = 1'b0;
         drive(tv[i].ctr, tv[i].pc, tv[i].pre, tv[i].ifbr, tv[i].brres, tv[i].fp);
         tick();
         exp_br  += int'(tv[i].e_push);
         exp_mis += int'(tv[i].e_mis);
         check($sformatf("v%0d_flush", i), 128'(flush_o), 128'(tv[i].e_flush));
         if (tv[i].e_flush) check($sformatf("v%0d_redirect", i), 128'(redirect_pc), 128'(tv[i].e_redir));
         check($sformatf("v%0d_upd_valid", i), 128'(upd_valid), 128'(tv[i].e_push));
         if (tv[i].e_push) begin
            hp = upd_pkt;
            check($sformatf("v%0d_pkt_mis", i), 128'(hp[7]), 128'(tv[i].e_mis));
            check($sformatf("v%0d_pkt_pc", i), 128'(hp[72:41]), 128'(tv[i].pc));
         end
         check($sformatf("v%0d_cnt_br", i), 128'(cnt_br), 128'(exp_br));
         check($sformatf("v%0d_cnt_mis", i), 128'(cnt_mis), 128'(exp_mis));
         if (!tv[i].e_flush) idle();
         tick();
         check($sformatf("v%0d_flush_drop", i), 128'(flush_o), 128'(0));
         check($sformatf("v%0d_shadow_br", i), 128'(cnt_br), 128'(exp_br));
         check($sformatf("v%0d_shadow_mis", i), 128'(cnt_mis), 128'(exp_mis));
         idle();
         upd_ready = 1'b1;
         tick();
         upd_ready = 1'b0;
      end

      // Backpressure: fill, hold the fifth branch, then pop+push while full
      do_reset();
      upd_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(32'd1, 32'h1c00_1000 + 32'(16 * k), mkpre(32'h0, 1'b0, 1'b1), 1'b0, 32'h0, 1'b0);
         tick();
      end
      drive(32'd1, 32'h1c00_1040, mkpre(32'h0, 1'b0, 1'b1), 1'b0, 32'h0, 1'b0);
      #1;
      check("bp_full_stall", 128'(stall_req), 128'(1));
      tick();
      check("bp_held_stall", 128'(stall_req), 128'(1));
      check("bp_held_cnt", 128'(cnt_br), 128'(4));
      hp = upd_pkt;
      check("bp_head_first", 128'(hp[72:41]), 128'(32'h1c00_1000));
      upd_ready = 1'b1;
      #1;
      check("bp_pop_unstall", 128'(stall_req), 128'(0));
      tick();
      idle();
      upd_ready = 1'b0;
      #1;
      check("bp_still_full", 128'(stall_req), 128'(1));
      check("bp_cnt5", 128'(cnt_br), 128'(5));
      hp = upd_pkt;
      check("bp_head_adv", 128'(hp[72:41]), 128'(32'h1c00_1010));
      upd_ready = 1'b1;
      got.delete();
      for (int n = 0; n < 10; n++) begin
         if (upd_valid) begin
            hp = upd_pkt;
            got.push_back(hp[72:41]);
         end
         tick();
      end
      want[0] = 32'h1c00_1010; want[1] = 32'h1c00_1020;
      want[2] = 32'h1c00_1030; want[3] = 32'h1c00_1040;
      check("bp_drain_n", 128'(got.size()), 128'(4));
      for (int n = 0; n < 4; n++)
         if (n < got.size()) check($sformatf("bp_order%0d", n), 128'(got[n]), 128'(want[n]));

      // Counter saturation on the narrow-counter instance
      do_reset();
      upd_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         drive(32'd1, 32'h1c00_2000 + 32'(4 * k), mkpre(32'h0, 1'b0, 1'b1), 1'b0, 32'h0, 1'b0);
         s_valid = 1'b1;
         tick();
      end
      idle();
      check("sat_br", 128'(s_cbr), 128'(3));
      check("sat_br_mis0", 128'(s_cmis), 128'(0));
      check("sat_main_br", 128'(cnt_br), 128'(5));
      for (int k = 0; k < 4; k++) begin
         drive(32'd3, 32'h1c00_3000 + 32'(4 * k), 76'h0, 1'b0, 32'h0, 1'b1);
         s_valid = 1'b1;
         tick();
         idle();
         tick();
      end
      check("sat_mis", 128'(s_cmis), 128'(3));
      check("sat_br_hold", 128'(s_cbr), 128'(3));
      check("sat_main_mis", 128'(cnt_mis), 128'(4));

      // Asynchronous reset with packets queued
      upd_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         drive(32'd1, 32'h1c00_4000 + 32'(4 * k), mkpre(32'h0, 1'b0, 1'b1), 1'b0, 32'h0, 1'b0);
         tick();
      end
      idle();
      check("rp_queued", 128'(upd_valid), 128'(1));
      rstn = 1'b0;
      #1;
      check("rp_upd_valid", 128'(upd_valid), 128'(0));
      check("rp_cnt_br", 128'(cnt_br), 128'(0));
      tick();
      rstn = 1'b1;
      tick();
      check("rp_after", 128'(upd_valid), 128'(0));

      // Random traffic against the model
      for (int n = 0; n < 2500; n++) begin
         ex_valid  = ($urandom_range(3, 0) != 0);
         ex_stall  = ($urandom_range(4, 0) == 0);
         case ($urandom_range(4, 0))
            0, 1:    ctr = 32'd1;
            2:       ctr = 32'd8;
            3:       ctr = 32'd2;
            default: ctr = $urandom();
         endcase
         pc        = $urandom() & 32'hffff_fffc;
         pre       = 76'({$urandom(), $urandom(), $urandom()});
         ifbr      = $urandom_range(1, 0) == 1;
         brresult  = ($urandom_range(1, 0) == 1) ? pre[31:0] : ($urandom() & 32'hffff_fffc);
         flush_pre = ($urandom_range(15, 0) == 0);
         upd_ready = ($urandom_range(2, 0) != 0);
         tick();
      end
      idle();
      upd_ready = 1'b1;
      repeat (8) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
